// File: rtl/adc_pattern_pkg.sv
// Shared types and helpers for the ADC test-pattern generator.
package adc_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_TRI   = 2'd1,
    MODE_SAW   = 2'd2,
    MODE_SQ    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  function automatic int unsigned mid(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

  // Operands arrive zero-extended, so max - min cannot underflow once min < max holds.
  function automatic logic cfg_valid(input mode_t mode, input int unsigned min_v,
                                     input int unsigned max_v, input int unsigned step_v);
    logic ok;
    ok = (min_v < max_v);
    if (mode != MODE_CONST && step_v == 0) ok = 1'b0;
    if (ok && (mode == MODE_TRI || mode == MODE_SAW) && step_v > max_v - min_v) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/adc_pattern_cfg.sv
// Config shadow register: validates cfg_load requests, holds one pending
// config and swaps it into the active set when the waveform allows.
module adc_pattern_cfg
  import adc_pattern_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEF_MIN  = 1,
  parameter int DEF_MAX  = 254,
  parameter int DEF_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_min,
  input  logic [DATA_W-1:0] cfg_max,
  input  logic [DATA_W-1:0] cfg_step,
  input  logic              apply_window,
  output logic              apply,
  output mode_t             act_mode,
  output logic [DATA_W-1:0] act_min,
  output logic [DATA_W-1:0] act_max,
  output logic [DATA_W-1:0] act_step,
  output logic [DATA_W-1:0] new_min,
  output logic              cfg_ack,
  output logic              cfg_err
);

  mode_t             load_mode;
  logic              load_ok;
  logic              pend;
  mode_t             sh_mode;
  logic [DATA_W-1:0] sh_min;
  logic [DATA_W-1:0] sh_max;
  logic [DATA_W-1:0] sh_step;

  assign load_mode = mode_t'(cfg_mode);
  assign load_ok   = cfg_valid(load_mode, 32'(cfg_min), 32'(cfg_max), 32'(cfg_step));
  assign apply     = pend & apply_window;
  assign new_min   = sh_min;

  // A rejected request leaves any earlier pending config in place.
  always_ff @(posedge clk) begin
    if (cfg_load && load_ok) begin
      sh_mode <= load_mode;
      sh_min  <= cfg_min;
      sh_max  <= cfg_max;
      sh_step <= cfg_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
      act_mode <= MODE_TRI;
      act_min  <= DATA_W'(DEF_MIN);
      act_max  <= DATA_W'(DEF_MAX);
      act_step <= DATA_W'(DEF_STEP);
    end else begin
      cfg_ack <= apply;
      cfg_err <= cfg_load & ~load_ok;
      if (apply) begin
        act_mode <= sh_mode;
        act_min  <= sh_min;
        act_max  <= sh_max;
        act_step <= sh_step;
      end
      // A load coinciding with an apply becomes the next pending config.
      if (cfg_load && load_ok) pend <= 1'b1;
      else if (apply)          pend <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_pattern_gen.sv
// ADC stand-in waveform source: constant, triangle, sawtooth or square
// samples on each sample_en tick, with calibration hold and period counting.
module adc_pattern_gen
  import adc_pattern_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16,
  parameter int DEF_MIN  = 1,
  parameter int DEF_MAX  = 254,
  parameter int DEF_STEP = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              sample_en,
  input  logic              en,
  input  logic              cal_hold,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_min,
  input  logic [DATA_W-1:0] cfg_max,
  input  logic [DATA_W-1:0] cfg_step,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [DATA_W-1:0] ad_data,
  output logic              dir,
  output logic              cycle_done,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam logic [DATA_W-1:0] MID   = DATA_W'(mid(DATA_W));
  localparam logic [DATA_W:0]   ONE_W = (DATA_W+1)'(1);

  state_t            state;
  logic [DATA_W-1:0] sq_cnt;

  mode_t             act_mode;
  logic [DATA_W-1:0] act_min;
  logic [DATA_W-1:0] act_max;
  logic [DATA_W-1:0] act_step;
  logic [DATA_W-1:0] new_min;
  logic              apply;
  logic              apply_window;

  state_t            wave_state;
  logic [DATA_W-1:0] wave_data;
  logic              wave_dir;
  logic [DATA_W-1:0] wave_cnt;
  logic              wave_done;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   lim_w;
  logic [DATA_W:0]   cnt_w;

  state_t            state_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              dir_nxt;
  logic [DATA_W-1:0] cnt_nxt;
  logic              done_nxt;

  function automatic logic [DATA_W-1:0] clamp_mid(input logic [DATA_W-1:0] lo,
                                                  input logic [DATA_W-1:0] hi);
    if (MID < lo)      return lo;
    else if (MID > hi) return hi;
    else               return MID;
  endfunction

  adc_pattern_cfg #(
    .DATA_W   (DATA_W),
    .DEF_MIN  (DEF_MIN),
    .DEF_MAX  (DEF_MAX),
    .DEF_STEP (DEF_STEP)
  ) u_cfg (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .cfg_load     (cfg_load),
    .cfg_mode     (cfg_mode),
    .cfg_min      (cfg_min),
    .cfg_max      (cfg_max),
    .cfg_step     (cfg_step),
    .apply_window (apply_window),
    .apply        (apply),
    .act_mode     (act_mode),
    .act_min      (act_min),
    .act_max      (act_max),
    .act_step     (act_step),
    .new_min      (new_min),
    .cfg_ack      (cfg_ack),
    .cfg_err      (cfg_err)
  );

  // Free-running waveform step, ignoring cal_hold and config swaps.
  always_comb begin
    wave_state = state;
    wave_data  = ad_data;
    wave_dir   = dir;
    wave_cnt   = sq_cnt;
    wave_done  = 1'b0;
    sum_w      = {1'b0, ad_data} + {1'b0, act_step};
    lim_w      = {1'b0, act_min} + {1'b0, act_step};
    cnt_w      = {1'b0, sq_cnt} + ONE_W;
    if (en) begin
      if (state == ST_HOLD) begin
        wave_data  = clamp_mid(act_min, act_max);
        wave_state = ST_UP;
        wave_dir   = 1'b0;
        wave_cnt   = '0;
      end else begin
        case (act_mode)
          MODE_TRI: begin
            if (state == ST_UP) begin
              if (sum_w >= {1'b0, act_max}) begin
                wave_data  = act_max;
                wave_dir   = 1'b1;
                wave_state = ST_DOWN;
              end else begin
                wave_data = sum_w[DATA_W-1:0];
              end
            end else begin
              if ({1'b0, ad_data} <= lim_w) begin
                wave_data  = act_min;
                wave_dir   = 1'b0;
                wave_state = ST_UP;
                wave_done  = 1'b1;
              end else begin
                wave_data = ad_data - act_step;
              end
            end
          end
          MODE_SAW: begin
            wave_dir   = 1'b0;
            wave_state = ST_UP;
            if (sum_w > {1'b0, act_max}) begin
              wave_data = act_min;
              wave_done = 1'b1;
            end else begin
              wave_data = sum_w[DATA_W-1:0];
            end
          end
          MODE_SQ: begin
            wave_state = ST_UP;
            if (cnt_w >= {1'b0, act_step}) begin
              wave_cnt = '0;
              if (dir) begin
                wave_data = act_min;
                wave_dir  = 1'b0;
                wave_done = 1'b1;
              end else begin
                wave_data = act_max;
                wave_dir  = 1'b1;
              end
            end else begin
              wave_cnt = cnt_w[DATA_W-1:0];
            end
          end
          default: begin
            wave_data  = act_min;
            wave_dir   = 1'b0;
            wave_state = ST_UP;
          end
        endcase
      end
    end
  end

  assign apply_window = sample_en & ~cal_hold &
                        ((state == ST_HOLD) | ~en | (act_mode == MODE_CONST) | wave_done);

  // cal_hold overrides everything; a config swap replaces the boundary sample.
  always_comb begin
    state_nxt = wave_state;
    data_nxt  = wave_data;
    dir_nxt   = wave_dir;
    cnt_nxt   = wave_cnt;
    done_nxt  = wave_done;
    if (cal_hold) begin
      state_nxt = ST_HOLD;
      data_nxt  = MID;
      dir_nxt   = 1'b0;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
    end else if (apply) begin
      state_nxt = (state == ST_HOLD && !en) ? ST_HOLD : ST_UP;
      data_nxt  = new_min;
      dir_nxt   = 1'b0;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_HOLD;
      ad_data    <= MID;
      dir        <= 1'b0;
      sq_cnt     <= '0;
      cycle_done <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      cycle_done <= sample_en & done_nxt;
      if (sample_en) begin
        state   <= state_nxt;
        ad_data <= data_nxt;
        dir     <= dir_nxt;
        sq_cnt  <= cnt_nxt;
        if (done_nxt) cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Scoreboard bench for adc_pattern_gen: directed ticks queue expected samples,
// a monitor compares every sample the DUT produces.
module tb_adc_pattern_gen;

  typedef struct packed {
    logic [7:0]  data;
    logic        dir;
    logic        done;
    logic        ack;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        en = 1'b0;
  logic        cal_hold = 1'b0;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [7:0]  cfg_min = 8'd0;
  logic [7:0]  cfg_max = 8'd0;
  logic [7:0]  cfg_step = 8'd0;
  logic        cfg_ack, cfg_err, dir, cycle_done;
  logic [7:0]  ad_data;
  logic [15:0] cycle_cnt;

  logic        rst2_n = 1'b0;
  logic        ack2, err2, dir2, done2;
  logic [7:0]  data2;
  logic [1:0]  cnt2;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_smp = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        se_q = 1'b0;
  exp_t        q[$];

  always #5 sys_clk = ~sys_clk;

  adc_pattern_gen dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sample_en  (sample_en),
    .en         (en),
    .cal_hold   (cal_hold),
    .cfg_load   (cfg_load),
    .cfg_mode   (cfg_mode),
    .cfg_min    (cfg_min),
    .cfg_max    (cfg_max),
    .cfg_step   (cfg_step),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .ad_data    (ad_data),
    .dir        (dir),
    .cycle_done (cycle_done),
    .cycle_cnt  (cycle_cnt)
  );

  adc_pattern_gen #(.DATA_W(8), .CNT_W(2), .DEF_MIN(1), .DEF_MAX(3), .DEF_STEP(1)) dut2 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (rst2_n),
    .sample_en  (1'b1),
    .en         (1'b1),
    .cal_hold   (1'b0),
    .cfg_load   (1'b0),
    .cfg_mode   (2'd0),
    .cfg_min    (8'd0),
    .cfg_max    (8'd0),
    .cfg_step   (8'd0),
    .cfg_ack    (ack2),
    .cfg_err    (err2),
    .ad_data    (data2),
    .dir        (dir2),
    .cycle_done (done2),
    .cycle_cnt  (cnt2)
  );

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Queue the expected sample, then issue one sample_en tick plus an idle clock.
  task automatic tick(input int d, input int dr, input int dn, input int ak, input int er);
    exp_t e;
    if (dn != 0) exp_cnt = exp_cnt + 16'd1;
    e.data = 8'(d);
    e.dir  = (dr != 0);
    e.done = (dn != 0);
    e.ack  = (ak != 0);
    e.err  = (er != 0);
    e.cnt  = exp_cnt;
    q.push_back(e);
    sample_en = 1'b1;
    @(negedge sys_clk);
    sample_en = 1'b0;
    cfg_load  = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic load(input int m, input int lo, input int hi, input int st);
    cfg_mode = 2'(m);
    cfg_min  = 8'(lo);
    cfg_max  = 8'(hi);
    cfg_step = 8'(st);
    cfg_load = 1'b1;
  endtask

  always @(posedge sys_clk) se_q <= sample_en;

  always @(negedge sys_clk) begin
    exp_t e;
    exp_t a;
    if (se_q) begin
      n_smp++;
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sample%0d: unexpected sample data=%0d", n_smp, ad_data);
      end else begin
        e = q.pop_front();
        a.data = ad_data;
        a.dir  = dir;
        a.done = cycle_done;
        a.ack  = cfg_ack;
        a.err  = cfg_err;
        a.cnt  = cycle_cnt;
        if (a !== e) begin
          n_fail++;
          $display("FAIL sample%0d: got data=%0d dir=%0d done=%0d ack=%0d err=%0d cnt=%0d expected data=%0d dir=%0d done=%0d ack=%0d err=%0d cnt=%0d",
                   n_smp, a.data, a.dir, a.done, a.ack, a.err, a.cnt,
                   e.data, e.dir, e.done, e.ack, e.err, e.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d samples seen", n_smp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [1:0] e2;
    repeat (2) @(negedge sys_clk);
    check("rst_data", int'(ad_data), 128);
    check("rst_dir", int'(dir), 0);
    check("rst_cnt", int'(cycle_cnt), 0);
    check("rst_pulses", int'({cycle_done, cfg_ack, cfg_err}), 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    en = 1'b1;
    cal_hold = 1'b1;
    repeat (64) tick(128, 0, 0, 0, 0);
    cal_hold = 1'b0;
    for (int v = 128; v <= 253; v++) tick(v, 0, 0, 0, 0);
    tick(254, 1, 0, 0, 0);
    for (int v = 253; v >= 2; v--) tick(v, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    for (int v = 2; v <= 253; v++) tick(v, 0, 0, 0, 0);
    tick(254, 1, 0, 0, 0);
    for (int v = 253; v >= 2; v--) tick(v, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 0);

    for (int v = 2; v <= 5; v++) tick(v, 0, 0, 0, 0);
    load(1, 50, 50, 1);
    tick(6, 0, 0, 0, 1);
    tick(7, 0, 0, 0, 0);
    tick(8, 0, 0, 0, 0);
    load(2, 10, 20, 3);
    tick(9, 0, 0, 0, 0);
    for (int v = 10; v <= 253; v++) tick(v, 0, 0, 0, 0);
    tick(254, 1, 0, 0, 0);
    for (int v = 253; v >= 2; v--) tick(v, 1, 0, 0, 0);
    tick(10, 0, 0, 1, 0);

    tick(13, 0, 0, 0, 0);
    tick(16, 0, 0, 0, 0);
    tick(19, 0, 0, 0, 0);
    tick(10, 0, 1, 0, 0);
    load(3, 0, 255, 4);
    tick(13, 0, 0, 0, 0);
    tick(16, 0, 0, 0, 0);
    tick(19, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);

    repeat (3) tick(0, 0, 0, 0, 0);
    repeat (4) tick(255, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    load(1, 5, 100, 5);
    repeat (3) tick(0, 0, 0, 0, 0);
    repeat (4) tick(255, 1, 0, 0, 0);
    tick(5, 0, 0, 1, 0);

    for (int v = 10; v <= 95; v += 5) tick(v, 0, 0, 0, 0);
    tick(100, 1, 0, 0, 0);
    tick(95, 1, 0, 0, 0);
    tick(90, 1, 0, 0, 0);
    en = 1'b0;
    repeat (10) tick(90, 1, 0, 0, 0);
    en = 1'b1;
    for (int v = 85; v >= 10; v -= 5) tick(v, 1, 0, 0, 0);
    tick(5, 0, 1, 0, 0);

    cal_hold = 1'b1;
    tick(128, 0, 0, 0, 0);
    cal_hold = 1'b0;
    tick(100, 0, 0, 0, 0);
    tick(100, 1, 0, 0, 0);
    tick(95, 1, 0, 0, 0);
    load(2, 10, 20, 3);
    tick(90, 1, 0, 0, 0);

    #3 sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("midrst_data", int'(ad_data), 128);
    check("midrst_dir", int'(dir), 0);
    check("midrst_cnt", int'(cycle_cnt), 0);
    check("midrst_pulses", int'({cycle_done, cfg_ack, cfg_err}), 0);
    exp_cnt = 16'd0;
    sys_rst_n = 1'b1;
    for (int v = 128; v <= 140; v++) tick(v, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge sys_clk);
    check("queue_drained", q.size(), 0);

    rst2_n = 1'b1;
    k = 0;
    e2 = 2'd0;
    for (int i = 0; i < 100 && k < 5; i++) begin
      @(negedge sys_clk);
      if (done2) begin
        e2 = e2 + 2'd1;
        check($sformatf("wrap_cnt%0d", k), int'(cnt2), int'(e2));
        check($sformatf("wrap_data%0d", k), int'(data2), 1);
        k++;
      end
    end
    check("wrap_periods", k, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_pattern_gen.md
Name: adc_pattern_gen

Overview:
- Parametrised, synthesizable ADC test-waveform source. It drives an ad_data bus in place of a real ADC, for on-board self-test of the voltmeter/frequency path and for stimulus in scope-level benches.
- Generalises the fixed 8-bit triangle stimulus into four modes: constant, triangle, sawtooth and square.
- Supports configurable width, bounds and step, a calibration-hold input, a validated config handshake and period reporting.
- Sits between the ADC-clock tick source and the measurement chain's ad_data input.

Parameters:
- DATA_W, 8: sample width in bits.
- CNT_W, 16: width of the completed-period counter.
- DEF_MIN, 1: reset lower bound.
- DEF_MAX, 254: reset upper bound.
- DEF_STEP, 1: reset step (triangle/saw); half-period in samples (square).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset.
- sample_en  in  1  one-cycle tick; one output sample per tick (aligned to ad_clk falling edge).
- en  in  1  run enable; 0 freezes ad_data.
- cal_hold  in  1  force midscale (ADC calibration window).
- cfg_load  in  1  one-cycle request to load cfg_*.
- cfg_mode  in  2  0 CONST, 1 TRI, 2 SAW, 3 SQUARE.
- cfg_min  in  DATA_W  lower bound.
- cfg_max  in  DATA_W  upper bound.
- cfg_step  in  DATA_W  step or half-period.
- cfg_ack  out  1  pulse: config applied.
- cfg_err  out  1  pulse: config rejected.
- ad_data  out  DATA_W  generated sample.
- dir  out  1  0 rising, 1 falling.
- cycle_done  out  1  pulse at end of each waveform period.
- cycle_cnt  out  CNT_W  completed periods; wraps modulo 2^CNT_W.

Behaviour:
- Reset is asynchronous and active-low on sys_rst_n; single clock sys_clk.
- Reset values:
  - ad_data = MID (2^(DATA_W-1)); dir = 0; cycle_cnt = 0.
  - cfg_ack = cfg_err = cycle_done = 0.
  - Active config = {TRI, DEF_MIN, DEF_MAX, DEF_STEP}; state = HOLD.
- States:
  - HOLD → UP when cal_hold = 0 and en = 1.
  - UP ↔ DOWN (TRI only).
  - Any state → HOLD when cal_hold = 1.
- All updates occur only on sample_en cycles. Latency: the new ad_data is registered on the sample_en cycle and visible the next clock.
- cal_hold = 1 on a sample_en cycle: ad_data <= MID, dir <= 0, state HOLD. cal_hold has priority over en, mode and config.
- cal_hold release: first sample = MID clamped to [min, max]; state UP.
- en = 0: ad_data and state are held; no cycle_done.
- Arithmetic is done in DATA_W+1 bits; no wrap-around at the bus limits.
- TRI, UP state:
  - If data + step >= max: data <= max, dir <= 1, state DOWN (the peak sample is emitted once).
  - Otherwise data <= data + step.
- TRI, DOWN state:
  - If data <= min + step: data <= min, dir <= 0, state UP, cycle_done.
  - Otherwise data <= data - step.
- SAW:
  - If data + step > max: data <= min, cycle_done.
  - Otherwise data += step. dir stays 0.
- SQUARE:
  - Internal sample counter counts to step; then data toggles between min and max.
  - cycle_done pulses on each max→min transition. dir = 1 while at max.
- CONST: data = min; cycle_done never asserted.
- cycle_done is a one-clock pulse registered with the sample; cycle_cnt increments on the same cycle.
- Config handshake:
  - cfg_load captures cfg_* into a shadow register, then validates it.
  - Invalid means min >= max, or step == 0 (non-CONST), or step > max - min (TRI/SAW).
  - Invalid config: cfg_err pulses one cycle after cfg_load; the shadow is discarded and the active config is unchanged.
  - Valid config applies at the next period boundary (the cycle_done sample), or on the next sample_en if state is HOLD, en = 0, or the active mode is CONST.
  - On apply: cfg_ack pulses, data <= new min, dir <= 0, the square counter is cleared, and that sample emits no cycle_done.
  - A second cfg_load while one is pending overwrites the pending shadow; only one cfg_ack is issued.
  - A cfg_load on the same cycle as an apply is re-validated and becomes pending; it is not lost.
- Reset mid-operation: all state returns to reset values immediately; any pending config is dropped and no ack is issued.

Decomposition:
- Package adc_pattern_pkg:
  - Mode enum (MODE_CONST, MODE_TRI, MODE_SAW, MODE_SQ).
  - State enum (ST_HOLD, ST_UP, ST_DOWN).
  - Function mid(DATA_W).
  - Function cfg_valid(mode, min, max, step).
- Sub-module adc_pattern_cfg: shadow register, validation, pending flag, apply strobe, cfg_ack and cfg_err.
- Top level: waveform FSM, square counter and cycle counter.

Test Plan (DATA_W = 8 unless noted):
- Reset, then cal_hold = 1 for 64 ticks → ad_data = 128 throughout. Release → 128, 129, 130…; peak 254 appears exactly once; first cycle_done at value 1; cycle_done spacing thereafter 506 ticks; cycle_cnt increments by 1.
- SAW, min 10, max 20, step 3 → 10, 13, 16, 19, 10; cycle_done on each 10-after-19; dir stays 0.
- SQUARE, min 0, max 255, step 4 → four 0s, four 255s; cycle_done every 8 ticks; no overflow at 255.
- cfg_load with min 50, max 50 → cfg_err one cycle later, waveform unchanged. Valid load mid-triangle → cfg_ack only at the next cycle_done sample, followed by the new min.
- en = 0 for 10 ticks mid-ramp → ad_data frozen, no cycle_done. Resume continues from the same value and direction. sample_en coincident with cal_hold → output 128.
- Assert sys_rst_n low with a config pending → outputs return to reset values, no cfg_ack; after release the generator runs DEF config (1..254 triangle). With CNT_W = 2, after 4 periods cycle_cnt wraps 3→0.
